// File: rtl/aether_engine_sequencer_pkg.sv
// Shared Aether constants: decoder instruction codes, register/param codes and
// the sequencer state encoding.
package aether_engine_sequencer_pkg;

  localparam logic [3:0] INSTR_NOP = 4'h0;
  localparam logic [3:0] INSTR_RST = 4'h1;
  localparam logic [3:0] INSTR_RDR = 4'h2;
  localparam logic [3:0] INSTR_WRR = 4'h3;
  localparam logic [3:0] INSTR_LDW = 4'h4;
  localparam logic [3:0] INSTR_CNV = 4'h5;
  localparam logic [3:0] INSTR_DNS = 4'h6;

  localparam logic [3:0] RST_FULL  = 4'hF;
  localparam logic [3:0] REG_VERSN = 4'h0;
  localparam logic [3:0] REG_MSTRT = 4'h1;

  localparam int CMD_W = 24;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} seq_state_e;

  // Long ops hold the sequencer until the datapath reports completion.
  function automatic logic is_long_op(input logic [3:0] instr);
    return (instr == INSTR_LDW) || (instr == INSTR_CNV) || (instr == INSTR_DNS);
  endfunction

endpackage

// File: rtl/aether_engine_sequencer_fifo.sv
// Synchronous command FIFO with registered count, full and empty flags.
module aether_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push_i && !full_q;
    do_pop   = pop_i && !empty_q;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == '0);
    mem_d    = mem_q;
    if (do_push) mem_d[wr_ptr_q] = wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage carries data only, so it needs no reset.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/aether_engine_sequencer.sv
// Command sequencer: queues host commands and presents each one to the decoder for
// exactly one cycle, holding long ops until done and returning RDR data to the host.
module aether_engine_sequencer
  import aether_engine_sequencer_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [23:0] cmd_data_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [15:0] rsp_data_o,
  output logic [3:0]  instruction_o,
  output logic [3:0]  param_1_o,
  output logic [15:0] param_2_o,
  input  logic [15:0] dec_data_i,
  input  logic        op_done_i,
  output logic        busy_o,
  output logic        err_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  seq_state_e       state_q, state_d;
  logic [3:0]       instr_q, instr_d, p1_q, p1_d;
  logic [15:0]      p2_q, p2_d, rsp_data_q, rsp_data_d;
  logic             rsp_valid_q, rsp_valid_d, err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fifo_pop, fifo_full, fifo_empty;
  logic [CMD_W-1:0] fifo_head;

  assign fifo_pop = (state_q == IDLE) && !fifo_empty;

  aether_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(CMD_W)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (cmd_valid_i),
    .pop_i   (fifo_pop),
    .wdata_i (cmd_data_i),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Issue regs default to NOP/0 so the decoder sees each command for one cycle only.
  always_comb begin
    state_d     = state_q;
    instr_d     = INSTR_NOP;
    p1_d        = '0;
    p2_d        = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          {instr_d, p1_d, p2_d} = fifo_head;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = IDLE;
        if (instr_q == INSTR_RDR) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = dec_data_i;
        end else if (is_long_op(instr_q)) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else if ((instr_q == INSTR_RST) && (p1_q == RST_FULL)) begin
          err_d = 1'b0;
        end
      end
      WAIT: begin
        if (op_done_i) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      instr_q     <= INSTR_NOP;
      p1_q        <= '0;
      p2_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cmd_ready_o   = !fifo_full;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign instruction_o = instr_q;
  assign param_1_o     = p1_q;
  assign param_2_o     = p2_q;
  assign busy_o        = (state_q != IDLE) || !fifo_empty;
  assign err_o         = err_q;

endmodule

// File: tb/tb_aether_engine_sequencer.sv
// Bench for aether_engine_sequencer: directed scenarios plus random traffic, all
// checked every cycle against a queue-based behavioural model.
module tb_aether_engine_sequencer;
  import aether_engine_sequencer_pkg::*;

  localparam int DEPTH = 4;
  localparam int TO    = 8;

  logic        clk_i = 1'b0, rst_ni = 1'b0;
  logic        cmd_valid_i = 1'b0, rsp_ready_i = 1'b0, op_done_i = 1'b0;
  logic [23:0] cmd_data_i = '0;
  logic [15:0] dec_data_i = '0;
  logic        cmd_ready_o, rsp_valid_o, busy_o, err_o;
  logic [15:0] rsp_data_o, param_2_o;
  logic [3:0]  instruction_o, param_1_o;

  int tests = 0;
  int fails = 0;

  aether_engine_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_data_i(cmd_data_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .instruction_o(instruction_o), .param_1_o(param_1_o),
    .param_2_o(param_2_o), .dec_data_i(dec_data_i), .op_done_i(op_done_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  // Behavioural model: a queue of pending commands plus the activity in progress.
  typedef enum int {M_IDLE, M_ISSUE, M_WAIT, M_RESP} mphase_t;
  logic [23:0] mq[$];
  mphase_t     ph = M_IDLE;
  logic [23:0] cur = '0;
  int          waited = 0;
  bit          m_err = 0, m_rv = 0, take = 0;
  logic [15:0] m_rd = '0;

  function automatic bit is_long(input logic [3:0] i);
    return (i == INSTR_LDW) || (i == INSTR_CNV) || (i == INSTR_DNS);
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mq.delete();
      ph = M_IDLE; cur = '0; waited = 0; m_err = 0; m_rv = 0; m_rd = '0;
    end else begin
      take = cmd_valid_i && (mq.size() < DEPTH);
      case (ph)
        M_IDLE: if (mq.size() > 0) begin cur = mq.pop_front(); ph = M_ISSUE; end
        M_ISSUE: begin
          if (cur[23:20] == INSTR_RDR) begin m_rd = dec_data_i; m_rv = 1; ph = M_RESP; end
          else if (is_long(cur[23:20])) begin waited = 0; ph = M_WAIT; end
          else begin
            if (cur[23:20] == INSTR_RST && cur[19:16] == RST_FULL) m_err = 0;
            ph = M_IDLE;
          end
        end
        M_WAIT: begin
          if (op_done_i) ph = M_IDLE;
          else begin
            waited++;
            if (waited == TO) begin m_err = 1; ph = M_IDLE; end
          end
        end
        M_RESP: if (rsp_ready_i) begin m_rv = 0; ph = M_IDLE; end
        default: ph = M_IDLE;
      endcase
      if (take) mq.push_back(cmd_data_i);
    end
  end

  always @(negedge clk_i) begin
    if (rst_ni) begin
      chk("instruction", 32'(instruction_o), 32'((ph == M_ISSUE) ? cur[23:20] : INSTR_NOP));
      chk("param_1", 32'(param_1_o), 32'((ph == M_ISSUE) ? cur[19:16] : 4'h0));
      chk("param_2", 32'(param_2_o), 32'((ph == M_ISSUE) ? cur[15:0] : 16'h0));
      chk("cmd_ready", 32'(cmd_ready_o), 32'(mq.size() < DEPTH));
      chk("busy", 32'(busy_o), 32'((ph != M_IDLE) || (mq.size() != 0)));
      chk("err", 32'(err_o), 32'(m_err));
      chk("rsp_valid", 32'(rsp_valid_o), 32'(m_rv));
      chk("rsp_data", 32'(rsp_data_o), 32'(m_rd));
    end
  end

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_instr"}, 32'(instruction_o), 32'(INSTR_NOP));
    chk({tag, "_p1"}, 32'(param_1_o), 32'h0);
    chk({tag, "_p2"}, 32'(param_2_o), 32'h0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'h0);
    chk({tag, "_rsp_data"}, 32'(rsp_data_o), 32'h0);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready_o), 32'h1);
    chk({tag, "_busy"}, 32'(busy_o), 32'h0);
    chk({tag, "_err"}, 32'(err_o), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    int n;
    logic [3:0] ins, p1;
    repeat (3) @(negedge clk_i);
    check_reset_values("reset");
    rst_ni = 1'b1;
    step();

    // WRR: one issue cycle, then NOP and idle
    cmd_valid_i = 1; cmd_data_i = {INSTR_WRR, REG_MSTRT, 16'h1234};
    step(); cmd_valid_i = 0;
    chk("t1_busy_queued", 32'(busy_o), 32'h1);
    step();
    chk("t1_instr", 32'(instruction_o), 32'(INSTR_WRR));
    chk("t1_p2", 32'(param_2_o), 32'h1234);
    step();
    chk("t1_instr_after", 32'(instruction_o), 32'(INSTR_NOP));
    chk("t1_busy_after", 32'(busy_o), 32'h0);

    // RDR with stalled response and a queued WRR behind it
    cmd_valid_i = 1; cmd_data_i = {INSTR_RDR, REG_VERSN, 16'h0000};
    step();
    cmd_data_i = {INSTR_WRR, REG_MSTRT, 16'h5555}; dec_data_i = 16'hA5A5;
    step(); cmd_valid_i = 0;
    chk("t2_instr_rdr", 32'(instruction_o), 32'(INSTR_RDR));
    step(); dec_data_i = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      chk("t2_rsp_valid", 32'(rsp_valid_o), 32'h1);
      chk("t2_rsp_data", 32'(rsp_data_o), 32'hA5A5);
      chk("t2_hold_nop", 32'(instruction_o), 32'(INSTR_NOP));
      step();
    end
    rsp_ready_i = 1;
    step(); rsp_ready_i = 0;
    chk("t2_rsp_drop", 32'(rsp_valid_o), 32'h0);
    step();
    chk("t2_next_wrr", 32'(instruction_o), 32'(INSTR_WRR));
    step();

    // CNV held until op_done, WRR behind it
    cmd_valid_i = 1; cmd_data_i = {INSTR_CNV, 4'h2, 16'h0100};
    step();
    cmd_data_i = {INSTR_WRR, REG_MSTRT, 16'h0042};
    step(); cmd_valid_i = 0;
    chk("t3_instr_cnv", 32'(instruction_o), 32'(INSTR_CNV));
    chk("t3_p1", 32'(param_1_o), 32'h2);
    chk("t3_p2", 32'(param_2_o), 32'h0100);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("t3_wait_nop", 32'(instruction_o), 32'(INSTR_NOP));
      step();
    end
    op_done_i = 1;
    step(); op_done_i = 0;
    chk("t3_done_nop", 32'(instruction_o), 32'(INSTR_NOP));
    step();
    chk("t3_wrr_after_done", 32'(param_2_o), 32'h0042);
    step();

    // DNS timeout after TO wait cycles, then RST_FULL clears err
    cmd_valid_i = 1; cmd_data_i = {INSTR_DNS, 4'h0, 16'h0000};
    step(); cmd_valid_i = 0;
    step();
    chk("t4_instr_dns", 32'(instruction_o), 32'(INSTR_DNS));
    step();
    repeat (TO - 1) step();
    chk("t4_err_early", 32'(err_o), 32'h0);
    step();
    chk("t4_err_set", 32'(err_o), 32'h1);
    chk("t4_idle", 32'(busy_o), 32'h0);
    cmd_valid_i = 1; cmd_data_i = {INSTR_RST, RST_FULL, 16'h0000};
    step(); cmd_valid_i = 0;
    step();
    chk("t4_rst_err_held", 32'(err_o), 32'h1);
    step();
    chk("t4_err_cleared", 32'(err_o), 32'h0);

    // Fill with response path stalled
    cmd_valid_i = 1; cmd_data_i = {INSTR_RDR, REG_VERSN, 16'h0000};
    accepted = 0;
    for (int i = 0; i < 12; i++) begin
      if (cmd_ready_o) accepted++;
      step();
      cmd_data_i = {INSTR_WRR, 4'h3, 16'(i)};
    end
    chk("t5_accepted", 32'(accepted), 32'(DEPTH + 1));
    chk("t5_full_ready", 32'(cmd_ready_o), 32'h0);
    cmd_valid_i = 0; rsp_ready_i = 1;
    n = 0;
    while (busy_o && n < 40) begin step(); n++; end
    chk("t5_drained", 32'(busy_o), 32'h0);
    rsp_ready_i = 0;

    // Simultaneous push and pop with a single entry queued
    cmd_valid_i = 1; cmd_data_i = {INSTR_WRR, 4'h1, 16'h0001};
    step();
    cmd_data_i = {INSTR_WRR, 4'h1, 16'h0002};
    step(); cmd_valid_i = 0;
    chk("t5_pp_first", 32'(param_2_o), 32'h0001);
    step();
    chk("t5_pp_queued", 32'(busy_o), 32'h1);
    step();
    chk("t5_pp_second", 32'(param_2_o), 32'h0002);
    step();

    // Async reset during WAIT with three queued commands
    cmd_valid_i = 1; cmd_data_i = {INSTR_DNS, 4'h0, 16'h0000};
    step();
    cmd_data_i = {INSTR_WRR, 4'h1, 16'hBEEF};
    repeat (3) step();
    cmd_valid_i = 0;
    step();
    #2 rst_ni = 0;
    #1 check_reset_values("t6");
    @(negedge clk_i); #2 rst_ni = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6_no_issue", 32'(instruction_o), 32'(INSTR_NOP));
      chk("t6_idle", 32'(busy_o), 32'h0);
    end

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      n = $urandom_range(0, 19);
      ins = (n < 14) ? 4'(n % 7) : 4'(n - 4);
      p1 = ($urandom_range(0, 3) == 0) ? RST_FULL : 4'($urandom);
      cmd_valid_i = ($urandom_range(0, 2) != 0);
      cmd_data_i  = {ins, p1, 16'($urandom)};
      op_done_i   = ($urandom_range(0, 5) == 0);
      rsp_ready_i = ($urandom_range(0, 2) == 0);
      dec_data_i  = 16'($urandom);
      step();
      if (c == 1500) begin
        #2 rst_ni = 0;
        #1 check_reset_values("rand_rst");
        @(negedge clk_i); #2 rst_ni = 1;
      end
    end
    cmd_valid_i = 0; op_done_i = 0; rsp_ready_i = 1;
    n = 0;
    while (busy_o && n < 100) begin step(); n++; end
    chk("final_drained", 32'(busy_o), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
